// File: rtl/axis_pktfifo.sv
// Store-and-forward AXI-Stream packet FIFO: only complete packets are released
// downstream, with a cut-through fallback for packets larger than the buffer.
module axis_pktfifo #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int C_AXIS_USER_WIDTH = 1,
  parameter int LGFIFO            = 5
) (
  input  logic                         i_aclk,
  input  logic                         i_aresetn,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         S_AXIS_TLAST,
  input  logic [C_AXIS_USER_WIDTH-1:0] S_AXIS_TUSER,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST,
  output logic [C_AXIS_USER_WIDTH-1:0] M_AXIS_TUSER,
  output logic [LGFIFO:0]              o_fill,
  output logic [LGFIFO:0]              o_npackets
);

  localparam int WIDTH = C_AXIS_USER_WIDTH + 1 + C_AXIS_DATA_WIDTH;
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0]   FULL    = (LGFIFO+1)'(DEPTH);
  localparam logic [LGFIFO:0]   CNT_ONE = (LGFIFO+1)'(1);
  localparam logic [LGFIFO-1:0] PTR_ONE = LGFIFO'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  head;
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   fill, npackets, fill_next, npackets_next;
  logic              cut, s_ready;
  logic              wr, rd, wr_last, rd_last;

  assign head    = mem[rd_ptr];
  assign wr      = S_AXIS_TVALID && s_ready;
  assign rd      = M_AXIS_TVALID && M_AXIS_TREADY;
  assign wr_last = wr && S_AXIS_TLAST;
  assign rd_last = rd && M_AXIS_TLAST;

  // A beat is released only once its packet is complete, or when an oversize
  // packet has forced cut-through; reset masks it immediately.
  assign M_AXIS_TVALID = i_aresetn && (fill != '0) && ((npackets != '0) || cut);
  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = head[C_AXIS_DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = head[C_AXIS_DATA_WIDTH];
  assign M_AXIS_TUSER  = head[WIDTH-1 -: C_AXIS_USER_WIDTH];
  assign o_fill        = fill;
  assign o_npackets    = npackets;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    fill_next     = fill;
    npackets_next = npackets;
    unique case ({wr, rd})
      2'b10:   fill_next = fill + CNT_ONE;
      2'b01:   fill_next = fill - CNT_ONE;
      default: fill_next = fill;
    endcase
    unique case ({wr_last, rd_last})
      2'b10:   npackets_next = npackets + CNT_ONE;
      2'b01:   npackets_next = npackets - CNT_ONE;
      default: npackets_next = npackets;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      npackets <= '0;
      cut      <= 1'b0;
      s_ready  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      fill     <= fill_next;
      npackets <= npackets_next;
      // Reading the oversize packet's TLAST ends cut-through and wins over a new set.
      if (rd_last)
        cut <= 1'b0;
      else if ((fill == FULL) && (npackets == '0))
        cut <= 1'b1;
      s_ready  <= (fill_next != FULL);
    end
  end

  // NOTE: storage has no reset; pointers and counters alone define valid entries,
  // which keeps the array mappable onto distributed or block RAM.
  always_ff @(posedge i_aclk) begin
    if (wr) mem[wr_ptr] <= {S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TDATA};
  end

endmodule
